// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the integer pipeline: load funct3 encodings, the
// default data width and the register-file clear sequencer state type.
// No ports (package).
// -----------------------------------------------------------------------------
package rv_pkg;

  // Default architectural data width
  localparam int XLEN_DEFAULT = 32;

  // Load funct3 encodings (RV64I load group)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Register-file clear sequencer states
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/load_ext.sv
// -----------------------------------------------------------------------------
// load_ext
// Purely combinational load-result extender. Takes LSB-aligned raw load data
// and sign- or zero-extends the byte/half/word selected by func3. With
// enable low (non-load writeback) the data passes through untouched.
// Shared with the LSU data path, so it carries no pipeline knowledge.
//
// Ports:
//   writedata  in  XLEN  raw data, LSB-aligned
//   func3      in  3     load funct3
//   enable     in  1     1 = apply extension, 0 = pass through
//   wv         out XLEN  extended value
// -----------------------------------------------------------------------------
module load_ext
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] writedata,
  input  logic [2:0]      func3,
  input  logic            enable,
  output logic [XLEN-1:0] wv
);

  // Extension select; size casts of signed slices give sign extension, so no
  // zero-width replications appear when XLEN is 32.
  always_comb begin
    wv = writedata;
    if (enable) begin
      case (func3)
        F3_LB:   wv = XLEN'($signed(writedata[7:0]));
        F3_LH:   wv = XLEN'($signed(writedata[15:0]));
        F3_LW:   wv = XLEN'($signed(writedata[31:0]));
        F3_LBU:  wv = XLEN'(writedata[7:0]);
        F3_LHU:  wv = XLEN'(writedata[15:0]);
        F3_LWU:  wv = XLEN'(writedata[31:0]);
        default: wv = writedata;
      endcase
    end else begin
      wv = writedata;
    end
  end

endmodule

// File: rtl/regfile_bypass_ext.sv
// -----------------------------------------------------------------------------
// regfile_bypass_ext
// Integer register file between WB (write side) and ID (read side): two
// combinational read ports, one write port, load extension at writeback,
// optional same-cycle write-to-read bypass, and a post-reset sequencer that
// zeroes registers 1..NREG-1 one per cycle while holding busy high.
//
// Ports:
//   clk         in   1     clock, rising edge
//   rst         in   1     synchronous active-high reset, (re)starts clear
//   rs1, rs2    in   AW    read indices
//   rd          in   AW    write index
//   writedata   in   XLEN  raw WB result
//   regwrite    in   1     write enable
//   wb_is_load  in   1     apply load extension
//   func3_wb    in   3     load funct3 of WB instruction
//   readdata1   out  XLEN  contents of rs1
//   readdata2   out  XLEN  contents of rs2
//   busy        out  1     clear sequence running; stall ID and WB
// -----------------------------------------------------------------------------
module regfile_bypass_ext
  import rv_pkg::*;
#(
  parameter int   XLEN   = XLEN_DEFAULT,
  parameter int   NREG   = 32,
  parameter bit   BYPASS = 1'b1,
  localparam int  AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writedata,
  input  logic            regwrite,
  input  logic            wb_is_load,
  input  logic [2:0]      func3_wb,
  output logic [XLEN-1:0] readdata1,
  output logic [XLEN-1:0] readdata2,
  output logic            busy
);

  localparam logic [AW-1:0]   ZERO_IDX = AW'(1'b0);
  localparam logic [AW-1:0]   ONE_IDX  = AW'(1'b1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(NREG - 1);
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};

  rf_state_t       r_state;
  rf_state_t       w_state_nxt;
  logic [AW-1:0]   r_clr_idx;
  logic [AW-1:0]   w_clr_idx_nxt;
  logic            r_busy;
  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] w_wv;
  logic            w_wr_en;

  load_ext #(
    .XLEN (XLEN)
  ) u_load_ext (
    .writedata (writedata),
    .func3     (func3_wb),
    .enable    (wb_is_load),
    .wv        (w_wv)
  );

  // Writes are dropped while clearing, and x0 is never stored.
  assign w_wr_en = regwrite && (rd != ZERO_IDX) && !r_busy;
  assign busy    = r_busy;

  // Clear sequencer next-state: walk indices 1..NREG-1, then return to idle.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      RF_IDLE: begin
        w_state_nxt   = RF_IDLE;
        w_clr_idx_nxt = r_clr_idx;
      end
      RF_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + ONE_IDX;
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt = RF_IDLE;
        end else begin
          w_state_nxt = RF_CLEAR;
        end
      end
      default: begin
        w_state_nxt   = RF_IDLE;
        w_clr_idx_nxt = r_clr_idx;
      end
    endcase
  end

  // Sequencer state register; busy is registered from the next state so it
  // changes on the same edge as the state, never during the rst cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= ONE_IDX;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      r_busy    <= (w_state_nxt == RF_CLEAR);
    end
  end

  // Register storage: the clear walk owns the array while busy. A write
  // landing in an idle rst cycle is harmless because the walk that follows
  // zeroes every register again.
  always_ff @(posedge clk) begin
    if (r_busy) begin
      r_regs[r_clr_idx] <= ZERO_X;
    end else if (w_wr_en) begin
      r_regs[rd] <= w_wv;
    end
  end

  // Read port 1: x0 and busy force zero; a matching same-cycle write bypasses.
  always_comb begin
    readdata1 = ZERO_X;
    if ((rs1 == ZERO_IDX) || r_busy) begin
      readdata1 = ZERO_X;
    end else if (BYPASS && regwrite && (rd == rs1)) begin
      readdata1 = w_wv;
    end else begin
      readdata1 = r_regs[rs1];
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    readdata2 = ZERO_X;
    if ((rs2 == ZERO_IDX) || r_busy) begin
      readdata2 = ZERO_X;
    end else if (BYPASS && regwrite && (rd == rs2)) begin
      readdata2 = w_wv;
    end else begin
      readdata2 = r_regs[rs2];
    end
  end

endmodule

// File: tb/tb_regfile_bypass_ext.sv
// -----------------------------------------------------------------------------
// tb_regfile_bypass_ext
// Three instances driven in lock step: A (XLEN=32, NREG=32, bypass on),
// B (same, bypass off, shares A's inputs) and C (XLEN=64, NREG=16, bypass on).
// The driver pushes expected outputs from an array-based reference model
// into a queue each cycle; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_regfile_bypass_ext;
  import rv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A/B stimulus and outputs
  logic        rst_ab, rw_ab, ld_ab;
  logic [4:0]  rs1_ab, rs2_ab, rd_ab;
  logic [31:0] wd_ab;
  logic [2:0]  f3_ab;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_busy, b_busy;

  // C stimulus and outputs
  logic        rst_c, rw_c, ld_c;
  logic [3:0]  rs1_c, rs2_c, rd_c;
  logic [63:0] wd_c;
  logic [2:0]  f3_c;
  logic [63:0] c_rd1, c_rd2;
  logic        c_busy;

  regfile_bypass_ext #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst(rst_ab), .rs1(rs1_ab), .rs2(rs2_ab), .rd(rd_ab),
    .writedata(wd_ab), .regwrite(rw_ab), .wb_is_load(ld_ab), .func3_wb(f3_ab),
    .readdata1(a_rd1), .readdata2(a_rd2), .busy(a_busy));

  regfile_bypass_ext #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst_ab), .rs1(rs1_ab), .rs2(rs2_ab), .rd(rd_ab),
    .writedata(wd_ab), .regwrite(rw_ab), .wb_is_load(ld_ab), .func3_wb(f3_ab),
    .readdata1(b_rd1), .readdata2(b_rd2), .busy(b_busy));

  regfile_bypass_ext #(.XLEN(64), .NREG(16), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .rs1(rs1_c), .rs2(rs2_c), .rd(rd_c),
    .writedata(wd_c), .regwrite(rw_c), .wb_is_load(ld_c), .func3_wb(f3_c),
    .readdata1(c_rd1), .readdata2(c_rd2), .busy(c_busy));

  // Reference model: plain arrays plus a remaining-busy-cycles counter
  logic [63:0] m_ab [32];
  logic [63:0] m_c  [16];
  int          cnt_ab = 0;
  int          cnt_c  = 0;
  bit          init_ab = 1'b0;
  bit          init_c  = 1'b0;

  typedef struct {
    string       tag;
    bit          chk_ab;
    logic [31:0] a1, a2, b1, b2;
    logic        bsy_ab;
    bit          chk_c;
    logic [63:0] c1, c2;
    logic        bsy_c;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [63:0] ext(input logic [63:0] wd, input logic ld,
                                      input logic [2:0] f3);
    logic [63:0] r;
    r = wd;
    if (ld) begin
      case (f3)
        3'd0:    r = {{56{wd[7]}},  wd[7:0]};
        3'd1:    r = {{48{wd[15]}}, wd[15:0]};
        3'd2:    r = {{32{wd[31]}}, wd[31:0]};
        3'd4:    r = {56'd0, wd[7:0]};
        3'd5:    r = {48'd0, wd[15:0]};
        3'd6:    r = {32'd0, wd[31:0]};
        default: r = wd;
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] model_read(input bit is_c, input int rs,
      input bit byp, input logic rw, input int rd, input logic [63:0] wv);
    int cnt;
    cnt = is_c ? cnt_c : cnt_ab;
    if (rs == 0 || cnt > 0) return 64'd0;
    if (byp && rw && rd == rs) return wv;
    return is_c ? m_c[rs] : m_ab[rs];
  endfunction

  task automatic check(input string name, input string tag,
                       input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s [%s] actual=%h required=%h", name, tag, act, req);
    end
  endtask

  // One cycle: push expectation for current inputs, clock, advance model.
  task automatic tick(input string tag);
    exp_t        e;
    logic [63:0] wv_ab, wv_c, t;
    wv_ab = ext({32'd0, wd_ab}, ld_ab, f3_ab);
    wv_c  = ext(wd_c, ld_c, f3_c);
    e.tag    = tag;
    e.chk_ab = init_ab;
    t = model_read(1'b0, int'(rs1_ab), 1'b1, rw_ab, int'(rd_ab), wv_ab); e.a1 = t[31:0];
    t = model_read(1'b0, int'(rs2_ab), 1'b1, rw_ab, int'(rd_ab), wv_ab); e.a2 = t[31:0];
    t = model_read(1'b0, int'(rs1_ab), 1'b0, rw_ab, int'(rd_ab), wv_ab); e.b1 = t[31:0];
    t = model_read(1'b0, int'(rs2_ab), 1'b0, rw_ab, int'(rd_ab), wv_ab); e.b2 = t[31:0];
    e.bsy_ab = (cnt_ab > 0);
    e.chk_c  = init_c;
    e.c1 = model_read(1'b1, int'(rs1_c), 1'b1, rw_c, int'(rd_c), wv_c);
    e.c2 = model_read(1'b1, int'(rs2_c), 1'b1, rw_c, int'(rd_c), wv_c);
    e.bsy_c = (cnt_c > 0);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_ab) begin
      cnt_ab  = 31;
      init_ab = 1'b1;
      for (int i = 0; i < 32; i++) m_ab[i] = 64'd0;
    end else if (cnt_ab > 0) begin
      cnt_ab--;
    end else if (rw_ab && rd_ab != 5'd0) begin
      m_ab[rd_ab] = {32'd0, wv_ab[31:0]};
    end
    if (rst_c) begin
      cnt_c  = 15;
      init_c = 1'b1;
      for (int i = 0; i < 16; i++) m_c[i] = 64'd0;
    end else if (cnt_c > 0) begin
      cnt_c--;
    end else if (rw_c && rd_c != 4'd0) begin
      m_c[rd_c] = wv_c;
    end
    #1;
  endtask

  task automatic idle_all();
    rst_ab = 1'b0; rw_ab = 1'b0; ld_ab = 1'b0; f3_ab = 3'd0;
    rd_ab = 5'd0; wd_ab = 32'd0; rs1_ab = 5'd0; rs2_ab = 5'd0;
    rst_c = 1'b0; rw_c = 1'b0; ld_c = 1'b0; f3_c = 3'd0;
    rd_c = 4'd0; wd_c = 64'd0; rs1_c = 4'd0; rs2_c = 4'd0;
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk_ab) begin
        check("a_rd1",  e.tag, {32'd0, a_rd1}, {32'd0, e.a1});
        check("a_rd2",  e.tag, {32'd0, a_rd2}, {32'd0, e.a2});
        check("b_rd1",  e.tag, {32'd0, b_rd1}, {32'd0, e.b1});
        check("b_rd2",  e.tag, {32'd0, b_rd2}, {32'd0, e.b2});
        check("a_busy", e.tag, {63'd0, a_busy}, {63'd0, e.bsy_ab});
        check("b_busy", e.tag, {63'd0, b_busy}, {63'd0, e.bsy_ab});
      end
      if (e.chk_c) begin
        check("c_rd1",  e.tag, c_rd1, e.c1);
        check("c_rd2",  e.tag, c_rd2, e.c2);
        check("c_busy", e.tag, {63'd0, c_busy}, {63'd0, e.bsy_c});
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [2:0] f3_list [8];

  initial begin
    int k;
    idle_all();
    @(posedge clk);
    #1;

    // Reset both groups, then run through clear with reads and a dropped write
    rst_ab = 1'b1; rst_c = 1'b1;
    tick("reset");
    rst_ab = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 34; i++) begin
      rs1_ab = 5'($urandom); rs2_ab = 5'($urandom);
      rs1_c  = 4'($urandom); rs2_c  = 4'($urandom);
      if (i == 5) begin
        rw_ab = 1'b1; rd_ab = 5'd3; wd_ab = 32'hA5A5A5A5; rs1_ab = 5'd3;
        rw_c  = 1'b1; rd_c  = 4'd3; wd_c  = 64'h1234_5678_9ABC_DEF0; rs1_c = 4'd3;
      end else begin
        rw_ab = 1'b0; rw_c = 1'b0;
      end
      tick("clear");
    end
    idle_all();
    rs1_ab = 5'd3; rs2_ab = 5'd3; rs1_c = 4'd3; rs2_c = 4'd3;
    tick("dropped_write");

    // Basic write then read
    idle_all();
    rd_ab = 5'd5; wd_ab = 32'hDEADBEEF; rw_ab = 1'b1; rs1_ab = 5'd5;
    tick("basic_same");
    rw_ab = 1'b0;
    tick("basic_next");

    // Both ports bypass the same register
    rs1_ab = 5'd7; rs2_ab = 5'd7; rd_ab = 5'd7; wd_ab = 32'h12345678; rw_ab = 1'b1;
    tick("bypass_same");
    rw_ab = 1'b0;
    tick("bypass_next");

    // Writes to x0 are discarded
    rd_ab = 5'd0; wd_ab = 32'hFFFFFFFF; rw_ab = 1'b1; rs1_ab = 5'd0; rs2_ab = 5'd0;
    tick("x0_write");
    rw_ab = 1'b0;
    tick("x0_read");

    // Load extension of 0x000080F0 for every funct3
    f3_list = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd6, 3'd3, 3'd7};
    for (int i = 0; i < 8; i++) begin
      wd_ab = 32'h000080F0; ld_ab = 1'b1; f3_ab = f3_list[i]; rw_ab = 1'b1;
      rd_ab = 5'(10 + i); rs1_ab = rd_ab; rs2_ab = rd_ab;
      tick("ext_same");
    end
    idle_all();
    for (int i = 0; i < 8; i++) begin
      rs1_ab = 5'(10 + i); rs2_ab = 5'(17 - i);
      tick("ext_read");
    end

    // Wide instance: LW / LWU of 0x80000000
    idle_all();
    wd_c = 64'h0000_0000_8000_0000; ld_c = 1'b1; rw_c = 1'b1;
    f3_c = 3'd2; rd_c = 4'd3; rs1_c = 4'd3;
    tick("c_lw");
    f3_c = 3'd6; rd_c = 4'd4; rs1_c = 4'd4; rs2_c = 4'd3;
    tick("c_lwu");
    idle_all();
    rs1_c = 4'd3; rs2_c = 4'd4;
    tick("c_read");

    // Reset again mid-clear at clear cycle 10
    idle_all();
    rst_ab = 1'b1; rst_c = 1'b1;
    tick("rst_a");
    rst_ab = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 10; i++) tick("clear_a");
    rst_ab = 1'b1; rst_c = 1'b1;
    tick("rst_b");
    rst_ab = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 33; i++) tick("clear_b");
    for (int i = 1; i < 32; i++) begin
      rs1_ab = 5'(i); rs2_ab = 5'(32 - i);
      rs1_c  = 4'(i); rs2_c  = 4'(16 - i);
      tick("cleared_read");
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 700; i++) begin
      rst_ab = ($urandom_range(0, 199) == 0);
      rw_ab  = ($urandom_range(0, 3) != 0);
      rd_ab  = 5'($urandom);
      wd_ab  = $urandom;
      ld_ab  = 1'($urandom);
      f3_ab  = 3'($urandom);
      rs1_ab = ($urandom_range(0, 2) == 0) ? rd_ab : 5'($urandom);
      rs2_ab = ($urandom_range(0, 2) == 0) ? rd_ab : 5'($urandom);
      rst_c  = ($urandom_range(0, 199) == 0);
      rw_c   = ($urandom_range(0, 3) != 0);
      rd_c   = 4'($urandom);
      wd_c   = {$urandom, $urandom};
      ld_c   = 1'($urandom);
      f3_c   = 3'($urandom);
      rs1_c  = ($urandom_range(0, 2) == 0) ? rd_c : 4'($urandom);
      rs2_c  = ($urandom_range(0, 2) == 0) ? rd_c : 4'($urandom);
      tick("random");
    end
    idle_all();

    // Drain the scoreboard within a bounded number of cycles
    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_ext.md
Name: regfile_bypass_ext

Overview:
Parametrised successor to the pipeline's integer register file, with the same two asynchronous read ports and one write port. Adds:
- XLEN and register-count parameters.
- Load-result sign/zero extension at writeback, driven by func3_wb.
- Optional write-to-read bypass, which removes the WB->ID hazard.
- A post-reset clear sequencer that zeroes every register and reports busy.

It sits between the WB stage (write side) and the ID stage (read side) of the 5-stage pipeline.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64.
NREG, 32, number of architectural registers; power of 2, >= 2; register 0 is hardwired to zero.
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = the read returns the old value.
AW, $clog2(NREG), derived localparam (not overridable); width of register index fields.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset; starts the clear sequence.
rs1  in  AW  read port 1 index.
rs2  in  AW  read port 2 index.
rd  in  AW  write index.
writedata  in  XLEN  raw WB result (ALU result or raw load data, LSB-aligned).
regwrite  in  1  write enable.
wb_is_load  in  1  1 = apply load extension per func3_wb; 0 = write writedata unmodified.
func3_wb  in  3  load funct3 of the WB instruction.
readdata1  out  XLEN  contents of rs1.
readdata2  out  XLEN  contents of rs2.
busy  out  1  high while the clear sequence runs; the pipeline must stall ID and WB.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); no asynchronous logic.
- FSM states: IDLE, CLEAR.
  - Any cycle with rst=1: next state CLEAR, clr_idx <= 1.
  - In CLEAR: regfile[clr_idx] <= 0 each cycle, clr_idx increments. After writing NREG-1, next state IDLE.
  - CLEAR lasts NREG-1 cycles after rst deasserts (31 for the default).
  - busy = 1 in CLEAR, 0 in IDLE; busy is a registered output. During the rst cycle itself, busy reflects the prior state.
  - rst asserted mid-clear restarts clr_idx at 1.
- While busy:
  - readdata1 = readdata2 = 0.
  - regwrite is ignored (dropped, not queued).
- Extended write value wv, when wb_is_load=1:
  - 000 LB: sign-extend writedata[7:0].
  - 001 LH: sign-extend writedata[15:0].
  - 010 LW: sign-extend writedata[31:0] (identity when XLEN=32).
  - 100 LBU: zero-extend [7:0].
  - 101 LHU: zero-extend [15:0].
  - 110 LWU: zero-extend [31:0].
  - 011, 111: writedata unmodified.
  - When wb_is_load=0: wv = writedata.
- Write: in IDLE, if regwrite=1 and rd!=0, then regfile[rd] <= wv at the rising edge. Writes to rd=0 are discarded.
- Read, combinational:
  - readdataN = 0 if rsN==0.
  - Else, if BYPASS=1 and regwrite=1 and rd==rsN and not busy: readdataN = wv.
  - Else readdataN = regfile[rsN].
- Both read ports may address the same register and may both bypass in the same cycle.
- Register 0 storage is never written; it reads 0 in every state.
- Register contents before the first rst are undefined. Verification must apply rst before checking reads.

Decomposition:
- Shared package rv_pkg:
  - funct3 load constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_LWU.
  - XLEN default constant.
  - FSM state enum rf_state_t {RF_IDLE, RF_CLEAR}.
- One sub-module, load_ext (purely combinational, XLEN-parametrised). Inputs: writedata, func3, enable. Output: wv. It will be reused by the future LSU data path.

Test Plan:
- Reset and clear: rst high 1 cycle, then low. Required: busy=1 for exactly 31 cycles, then 0. All reads return 0 during and after clear. A regwrite issued during busy is lost (read afterwards = 0).
- Basic write then read: rd=5, writedata=0xDEADBEEF, regwrite=1, wb_is_load=0, BYPASS=0. Required: readdata1 (rs1=5) = old 0 in the same cycle; 0xDEADBEEF next cycle.
- Bypass: BYPASS=1, rs1=rs2=7, rd=7, writedata=0x12345678. Required: both readdata = 0x12345678 in the same cycle. rd=0 with writedata=0xFFFFFFFF and rs1=0 -> readdata1=0, and never stored.
- Extension: writedata=0x000080F0, wb_is_load=1. Required:
  - LB -> 0xFFFFFFF0
  - LBU -> 0x000000F0
  - LH -> 0xFFFF80F0
  - LHU -> 0x000080F0
  - LW -> 0x000080F0
- Reset mid-clear: assert rst again at clear cycle 10. Required: busy stays 1 for 31 more cycles after the second deassert; registers 1..31 read 0 at the end.
- Parameter sweep: XLEN=64, NREG=16 (AW=4). LW of 0x80000000 -> 0xFFFFFFFF80000000; LWU of the same -> 0x0000000080000000. Clear takes 15 cycles.
